// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI-Stream arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_e;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int MAX_SRC            = 8;

    // First requester at or after (last+1) mod num, rotating through at most MAX_SRC slots.
    function automatic logic [2:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                           input logic [2:0]         last,
                                           input int                 num);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            idx = (int'(last) + k) % num;
            if (!found && k <= num && req[3'(idx)]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer; the output is driven straight from the head register.
module axis_skid_buffer #(
    parameter int WIDTH = 67
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             full,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [1:0]       count;
    logic [WIDTH-1:0] head, tail;
    logic             push, pop;

    assign full      = (count == 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign push      = in_valid & ~full;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (count)
                2'd0: if (push) begin
                    head  <= in_data;
                    count <= 2'd1;
                end
                2'd1: case ({push, pop})
                    2'b10: begin
                        tail  <= in_data;
                        count <= 2'd2;
                    end
                    2'b11: head  <= in_data;
                    2'b01: count <= 2'd0;
                    default: ;
                endcase
                2'd2: if (pop) begin
                    head  <= tail;
                    count <= 2'd1;
                end
                default: count <= 2'd0;
            endcase
        end
    end
endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter: one source owns the output from first beat to TLAST.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int  NUM_SRC    = 4,
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int ID_WIDTH   = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [NUM_SRC-1:0]            S_AXIS_TVALID,
    output logic [NUM_SRC-1:0]            S_AXIS_TREADY,
    input  logic [NUM_SRC-1:0]            S_AXIS_TLAST,
    input  logic [NUM_SRC-1:0]            SRC_ENABLE,
    output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic                          M_AXIS_TLAST,
    output logic [ID_WIDTH-1:0]           M_AXIS_TID,
    output logic                          BUSY,
    output logic [31:0]                   PKT_COUNT
);
    localparam int BUF_W = DATA_WIDTH + 1 + ID_WIDTH;

    arb_state_e            state, state_nxt;
    logic [ID_WIDTH-1:0]   grant, last_grant, pick;
    logic [NUM_SRC-1:0]    req;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid, sel_last, accept, buf_full;
    logic [BUF_W-1:0]      buf_out;
    logic [31:0]           pkt_count;

    assign req  = S_AXIS_TVALID & SRC_ENABLE;
    assign pick = ID_WIDTH'(rr_pick(MAX_SRC'(req), 3'(last_grant), NUM_SRC));

    always_comb begin
        sel_data      = '0;
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        S_AXIS_TREADY = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant == ID_WIDTH'(i)) begin
                sel_data         = S_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid        = S_AXIS_TVALID[i];
                sel_last         = S_AXIS_TLAST[i];
                S_AXIS_TREADY[i] = (state == PASS) & ~buf_full;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (|req) state_nxt = PASS;
            PASS: begin
                accept = sel_valid & ~buf_full;
                if (accept && sel_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // last_grant starts at the top index so source 0 wins the first arbitration.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= ID_WIDTH'(NUM_SRC - 1);
            pkt_count  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |req) begin
                grant      <= pick;
                last_grant <= pick;
            end
            if (accept && sel_last) pkt_count <= pkt_count + 32'd1;
        end
    end

    axis_skid_buffer #(.WIDTH(BUF_W)) u_skid (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .in_data   ({sel_data, sel_last, grant}),
        .in_valid  (accept),
        .full      (buf_full),
        .out_data  (buf_out),
        .out_valid (M_AXIS_TVALID),
        .out_ready (M_AXIS_TREADY)
    );

    assign M_AXIS_TDATA = buf_out[BUF_W-1 -: DATA_WIDTH];
    assign M_AXIS_TLAST = buf_out[ID_WIDTH];
    assign M_AXIS_TID   = buf_out[ID_WIDTH-1:0];
    assign BUSY         = (state == PASS) | M_AXIS_TVALID;
    assign PKT_COUNT    = pkt_count;
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Randomized bench: per-source packet queues feed the DUT; a round-robin packet-order model predicts the output stream.
module tb_axis_packet_arbiter;
    localparam int NS = 4, DW = 64, IW = 2;
    localparam int M_GAPS = 1, M_RRDY = 2, M_BUB = 4;

    logic           CLK = 1'b0;
    logic           RESET_N;
    logic [NS*DW-1:0] S_AXIS_TDATA;
    logic [NS-1:0]  S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST, SRC_ENABLE;
    logic [DW-1:0]  M_AXIS_TDATA;
    logic           M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST, BUSY;
    logic [IW-1:0]  M_AXIS_TID;
    logic [31:0]    PKT_COUNT;

    axis_packet_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
        .SRC_ENABLE(SRC_ENABLE),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TID(M_AXIS_TID), .BUSY(BUSY), .PKT_COUNT(PKT_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic first; logic last; logic [DW-1:0] data; } beat_t;
    typedef struct packed { logic [IW-1:0] tid; logic last; logic [DW-1:0] data; } obeat_t;

    beat_t       srcq [NS][$];
    obeat_t      expq [$];
    int          m_last;
    logic [31:0] m_pkt;
    logic [NS-1:0] en_r;
    int          stall_lo = 0, stall_hi = 0;
    int          n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        S_AXIS_TVALID = '0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TLAST  = '0;
        M_AXIS_TREADY = 1'b1;
    endtask

    task automatic clear_q();
        for (int s = 0; s < NS; s++) srcq[s].delete();
        expq.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_tready"}, S_AXIS_TREADY, 0);
        chk({tag, "_m_tvalid"}, M_AXIS_TVALID, 0);
        chk({tag, "_m_tlast"},  M_AXIS_TLAST, 0);
        chk({tag, "_m_tdata"},  M_AXIS_TDATA, 0);
        chk({tag, "_m_tid"},    M_AXIS_TID, 0);
        chk({tag, "_busy"},     BUSY, 0);
        chk({tag, "_pkt"},      PKT_COUNT, 0);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        drive_idle();
        #1 chk_reset_vals("rst");
        @(negedge CLK);
        RESET_N = 1'b1;
        m_last  = NS - 1;
        m_pkt   = '0;
    endtask

    // seq >= 0 gives data seq, seq+1, ...; otherwise random data.
    task automatic add_pkt(input int s, input int len, input int seq);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.first = (i == 0);
            b.last  = (i == len - 1);
            b.data  = (seq >= 0) ? DW'(seq + i) : {$urandom, $urandom};
            srcq[s].push_back(b);
        end
    endtask

    // Whole-packet round robin over sources that still hold packets and are enabled.
    task automatic build_exp(input logic [NS-1:0] en_in, input int clr);
        int            ptr [NS];
        logic [NS-1:0] en;
        int            pick;
        beat_t         b;
        obeat_t        o;
        en = en_in;
        for (int s = 0; s < NS; s++) ptr[s] = 0;
        while (1) begin
            pick = -1;
            for (int k = 1; k <= NS; k++) begin
                int s;
                s = (m_last + k) % NS;
                if (pick < 0 && en[s] && ptr[s] < srcq[s].size()) pick = s;
            end
            if (pick < 0) break;
            do begin
                b = srcq[pick][ptr[pick]];
                ptr[pick]++;
                o.tid = IW'(pick); o.last = b.last; o.data = b.data;
                expq.push_back(o);
            end while (!b.last);
            m_last = pick;
            if (pick == clr) en[pick] = 1'b0;
        end
    endtask

    task automatic run(input int mode, input int clr, input int rst_after);
        int            cyc, acc, inflight, prev_cyc;
        logic          prev_last, hold_v;
        logic [DW+IW:0] held;
        logic [NS-1:0] vld;
        obeat_t        e;
        cyc = 0; acc = 0; inflight = 0; prev_cyc = -1; prev_last = 1'b1;
        hold_v = 1'b0; held = '0;
        while (expq.size() > 0 && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            SRC_ENABLE = en_r;
            for (int s = 0; s < NS; s++) begin
                vld[s] = 1'b0;
                S_AXIS_TDATA[s*DW +: DW] = '0;
                S_AXIS_TLAST[s] = 1'b0;
                if (srcq[s].size() > 0) begin
                    vld[s] = !((mode & M_GAPS) != 0 && !srcq[s][0].first && $urandom_range(0, 3) == 0);
                    S_AXIS_TDATA[s*DW +: DW] = srcq[s][0].data;
                    S_AXIS_TLAST[s] = srcq[s][0].last;
                end
            end
            S_AXIS_TVALID = vld;
            if (cyc >= stall_lo && cyc < stall_hi) M_AXIS_TREADY = 1'b0;
            else if ((mode & M_RRDY) != 0)       M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
            else                                 M_AXIS_TREADY = 1'b1;
            #1;
            chk("pkt_count", PKT_COUNT, m_pkt);
            chk("tready_onehot", $countones(S_AXIS_TREADY) <= 1, 1);
            if (hold_v) chk("m_stable", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TID, M_AXIS_TDATA}, {1'b1, held});
            hold_v = M_AXIS_TVALID && !M_AXIS_TREADY;
            held   = {M_AXIS_TLAST, M_AXIS_TID, M_AXIS_TDATA};
            if (stall_hi > 0 && cyc == stall_hi - 1) begin
                chk("stall_inflight", inflight, 2);
                chk("stall_s_tready", S_AXIS_TREADY, 0);
                chk("stall_busy", BUSY, 1);
            end
            for (int s = 0; s < NS; s++) begin
                if (S_AXIS_TVALID[s] && S_AXIS_TREADY[s]) begin
                    if (srcq[s][0].last) m_pkt++;
                    void'(srcq[s].pop_front());
                    acc++;
                    inflight++;
                    if (s == clr) en_r[s] = 1'b0;
                end
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                e = expq.pop_front();
                chk("m_tid",   M_AXIS_TID,   e.tid);
                chk("m_tdata", M_AXIS_TDATA, e.data);
                chk("m_tlast", M_AXIS_TLAST, e.last);
                if ((mode & M_BUB) != 0 && prev_cyc >= 0)
                    chk("beat_gap", cyc - prev_cyc, prev_last ? 2 : 1);
                prev_cyc  = cyc;
                prev_last = M_AXIS_TLAST;
                inflight--;
            end
            if (rst_after > 0 && acc >= rst_after) begin
                @(posedge CLK);
                #2;
                chk("pre_rst_busy", BUSY, 1);
                RESET_N = 1'b0;
                #1 chk_reset_vals("midrst");
                @(negedge CLK);
                drive_idle();
                clear_q();
                RESET_N = 1'b1;
                m_last  = NS - 1;
                m_pkt   = '0;
                return;
            end
        end
        chk("drained", expq.size(), 0);
        @(negedge CLK);
        drive_idle();
        clear_q();
        repeat (2) @(negedge CLK);
        #1;
        chk("busy_idle", BUSY, 0);
        chk("pkt_final", PKT_COUNT, m_pkt);
        stall_lo = 0;
        stall_hi = 0;
    endtask

    initial begin
        RESET_N    = 1'b1;
        SRC_ENABLE = '1;
        en_r       = '1;
        drive_idle();
        #2 do_reset();

        // single source, 4 beats 0..3
        add_pkt(0, 4, 0);
        build_exp(en_r, -1);
        run(M_BUB, -1, 0);
        chk("single_pkt", PKT_COUNT, 1);

        // round robin from reset: expected order 0,1,2,3,0 with one bubble between packets
        do_reset();
        en_r = '1;
        add_pkt(0, 2, 16'h100); add_pkt(0, 2, 16'h110);
        add_pkt(1, 2, 16'h200); add_pkt(2, 2, 16'h300); add_pkt(3, 2, 16'h400);
        build_exp(en_r, -1);
        run(M_BUB, -1, 0);

        // back-pressure: output stalled 5 cycles mid-packet
        en_r = '1;
        add_pkt(0, 8, 16'h500);
        stall_lo = 4; stall_hi = 9;
        build_exp(en_r, -1);
        run(0, -1, 0);

        // enable mask 1010, source 1 disabled during its packet
        en_r = 4'b1010;
        for (int s = 0; s < NS; s++) begin
            add_pkt(s, 3, -1);
            add_pkt(s, 3, -1);
        end
        build_exp(en_r, 1);
        run(0, 1, 0);

        // single-beat packets across the counter wrap
        en_r = '1;
        @(negedge CLK);
        force dut.pkt_count = 32'hFFFF_FFFF;
        @(negedge CLK);
        release dut.pkt_count;
        m_pkt = 32'hFFFF_FFFF;
        add_pkt(2, 1, 16'h600);
        add_pkt(3, 1, 16'h700);
        build_exp(en_r, -1);
        run(M_BUB, -1, 0);
        chk("pkt_wrap", PKT_COUNT, 1);

        // randomized traffic, masks, valid gaps and output stalls
        for (int it = 0; it < 15; it++) begin
            for (int s = 0; s < NS; s++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int p = 0; p < n; p++) add_pkt(s, $urandom_range(1, 6), -1);
            end
            en_r = NS'($urandom_range(1, 15));
            build_exp(en_r, -1);
            run(M_GAPS | M_RRDY, -1, 0);
        end

        // reset on beat 2 of a 4-beat packet, then source 0 must win first
        en_r = '1;
        add_pkt(1, 4, 16'h800);
        build_exp(en_r, -1);
        run(0, -1, 0);
        add_pkt(0, 4, 16'h900);
        build_exp(en_r, -1);
        run(0, -1, 2);
        for (int s = NS - 1; s >= 0; s--) add_pkt(s, 2, 16'hA00 + 16 * s);
        build_exp(en_r, -1);
        run(0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
